icache_tag_ctrl: RTL

- Lookup/fill controller that sits directly upstream of the 16-entry × 24-bit icache tag array.
- Drives the array's RW port 0 and consumes its dout0.
- Clears every entry after reset or on invalidate, because the array has no reset of its own.
- Performs tag compare for fetch requests; on a miss it requests a line fill, then writes the new tag with the valid bit set.

---
 rtl/icache_tag_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: lookup/fill controller for a 16-entry x 24-bit icache tag
// array. It clears the array after reset or on invalidate. It compares tags for
// fetch requests. On a miss it requests a line fill and then writes the new
// tag with its valid bit set.
module icache_tag_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 5,
    parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [INDEX_WIDTH-1:0] resp_index,
    output logic                   fill_req,
    output logic [ADDR_WIDTH-1:0]  fill_addr,
    input  logic                   fill_done,
    input  logic                   invalidate,
    output logic                   tag_csb0,
    output logic                   tag_web0,
    output logic [INDEX_WIDTH-1:0] tag_addr0,
    output logic [TAG_WIDTH:0]     tag_din0,
    input  logic [TAG_WIDTH:0]     tag_dout0
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_INIT_END = 3'd1;
    localparam logic [2:0] S_IDLE     = 3'd2;
    localparam logic [2:0] S_LOOKUP   = 3'd3;
    localparam logic [2:0] S_MISS     = 3'd4;
    localparam logic [2:0] S_WRITE    = 3'd5;
    localparam logic [2:0] S_WR_END   = 3'd6;

    logic [2:0]             state_reg;
    logic [INDEX_WIDTH-1:0] cnt_reg;
    logic [TAG_WIDTH-1:0]   tag_reg;
    logic [INDEX_WIDTH-1:0] index_reg;
    logic [ADDR_WIDTH-1:0]  fill_addr_reg;

    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]   req_tag;
    logic                   lookup_hit;
    logic                   offset_unused;

    assign req_index     = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_tag       = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    // The byte offset plays no part in the tag lookup.
    assign offset_unused = ^req_addr[OFFSET_WIDTH-1:0];

    // The array data is valid in LOOKUP because the read was issued from IDLE.
    assign lookup_hit = tag_dout0[TAG_WIDTH] && (tag_dout0[TAG_WIDTH-1:0] == tag_reg);

    // State, sweep counter and latched request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_INIT;
            cnt_reg       <= '0;
            tag_reg       <= '0;
            index_reg     <= '0;
            fill_addr_reg <= '0;
        end else begin
            case (state_reg)
                S_INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == {INDEX_WIDTH{1'b1}}) begin
                        state_reg <= S_INIT_END;
                    end
                end
                S_INIT_END: begin
                    cnt_reg   <= '0;
                    state_reg <= S_IDLE;
                end
                S_IDLE: begin
                    if (invalidate) begin
                        cnt_reg   <= '0;
                        state_reg <= S_INIT;
                    end else if (req_valid) begin
                        tag_reg   <= req_tag;
                        index_reg <= req_index;
                        state_reg <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        state_reg <= S_IDLE;
                    end else begin
                        fill_addr_reg <= {tag_reg, index_reg, {OFFSET_WIDTH{1'b0}}};
                        state_reg     <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (fill_done) begin
                        state_reg <= S_WRITE;
                    end
                end
                S_WRITE:  state_reg <= S_WR_END;
                S_WR_END: state_reg <= S_IDLE;
                default:  state_reg <= S_INIT;
            endcase
        end
    end

    // Array port and handshake outputs decoded from the current state.
    always_comb begin
        tag_csb0   = 1'b1;
        tag_web0   = 1'b1;
        tag_addr0  = '0;
        tag_din0   = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        fill_req   = 1'b0;
        case (state_reg)
            S_INIT: begin
                tag_csb0  = 1'b0;
                tag_web0  = 1'b0;
                tag_addr0 = cnt_reg;
            end
            S_INIT_END: begin
                // A dummy read clears the write enable that the array latched for the last sweep write.
                tag_csb0 = 1'b0;
            end
            S_IDLE: begin
                req_ready = 1'b1;
                if (!invalidate && req_valid) begin
                    tag_csb0  = 1'b0;
                    tag_addr0 = req_index;
                end
            end
            S_LOOKUP: begin
                resp_valid = lookup_hit;
                resp_hit   = lookup_hit;
            end
            S_MISS: begin
                fill_req = 1'b1;
            end
            S_WRITE: begin
                tag_csb0  = 1'b0;
                tag_web0  = 1'b0;
                tag_addr0 = index_reg;
                tag_din0  = {1'b1, tag_reg};
            end
            S_WR_END: begin
                tag_csb0   = 1'b0;
                tag_addr0  = index_reg;
                resp_valid = 1'b1;
            end
            default: begin
                tag_csb0 = 1'b1;
            end
        endcase
        // Keep the array deselected while reset is held.
        if (!rst_n) begin
            tag_csb0  = 1'b1;
            tag_web0  = 1'b1;
            tag_addr0 = '0;
            tag_din0  = '0;
        end
    end

    assign resp_index = index_reg;
    assign fill_addr  = fill_addr_reg;

endmodule
